// File: rtl/fpu_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one multi-cycle FP unit between two requesters.
// One operation in flight at a time; a watchdog aborts operations the unit never finishes.
module fpu_share_arbiter #(
  parameter int W         = 32,
  parameter int OPW       = 4,
  parameter int TO_CYCLES = 64
) (
  input  logic           CLK,
  input  logic           reset,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [OPW-1:0] req0_op,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [OPW-1:0] req1_op,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  output logic           rsp0_valid,
  output logic [W-1:0]   rsp0_data,
  output logic           rsp0_err,
  output logic           rsp1_valid,
  output logic [W-1:0]   rsp1_data,
  output logic           rsp1_err,
  output logic           fu_start,
  output logic [OPW-1:0] fu_op,
  output logic [W-1:0]   fu_a,
  output logic [W-1:0]   fu_b,
  input  logic           fu_done,
  input  logic [W-1:0]   fu_result,
  output logic           fu_abort,
  output logic           busy,
  output logic           timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [7:0] TO_LAST = 8'(TO_CYCLES - 1);

  state_t         state_q, state_d;
  logic           owner_q;
  logic           last_grant_q;
  logic [7:0]     cnt_q;
  logic [OPW-1:0] op_q;
  logic [W-1:0]   a_q, b_q;
  logic [W-1:0]   rsp_data_q;
  logic           rsp_err_q;
  logic           timeout_err_q;

  logic grant0, grant1, take, timeout_hit;

  // On a tie the requester that did not win last time is granted.
  assign grant0 = req0_valid && (!req1_valid || last_grant_q);
  assign grant1 = req1_valid && (!req0_valid || !last_grant_q);

  assign req0_ready  = (state_q == IDLE) && grant0;
  assign req1_ready  = (state_q == IDLE) && grant1;
  assign take        = req0_ready || req1_ready;
  assign timeout_hit = (state_q == WAIT) && !fu_done && (cnt_q == TO_LAST);

  // NOTE: every output of a combinational process gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (take) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (fu_done || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      cnt_q         <= '0;
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take) begin
        op_q         <= req1_ready ? req1_op : req0_op;
        a_q          <= req1_ready ? req1_a  : req0_a;
        b_q          <= req1_ready ? req1_b  : req0_b;
        owner_q      <= req1_ready;
        last_grant_q <= req1_ready;
      end
      if (state_q == ISSUE) cnt_q <= '0;
      if (state_q == WAIT) begin
        // A done arriving on the last watchdog cycle still counts as success.
        if (fu_done) begin
          rsp_data_q <= fu_result;
          rsp_err_q  <= 1'b0;
        end else if (timeout_hit) begin
          rsp_data_q    <= '0;
          rsp_err_q     <= 1'b1;
          timeout_err_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
      end
    end
  end

  assign rsp0_valid  = (state_q == RESP) && !owner_q;
  assign rsp1_valid  = (state_q == RESP) &&  owner_q;
  assign rsp0_data   = rsp0_valid ? rsp_data_q : '0;
  assign rsp1_data   = rsp1_valid ? rsp_data_q : '0;
  assign rsp0_err    = rsp0_valid && rsp_err_q;
  assign rsp1_err    = rsp1_valid && rsp_err_q;
  assign fu_start    = (state_q == ISSUE);
  assign fu_abort    = timeout_hit;
  assign fu_op       = op_q;
  assign fu_a        = a_q;
  assign fu_b        = b_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// Self-checking bench for fpu_share_arbiter: vector table of operations, an FP-unit model
// with programmable latency, and a response scoreboard fed at each transfer.
module tb_fpu_share_arbiter;

  localparam int W   = 32;
  localparam int OPW = 4;
  localparam int TO  = 8;

  logic           CLK = 1'b0;
  logic           reset = 1'b1;
  logic           req0_valid = 1'b0, req1_valid = 1'b0;
  logic           req0_ready, req1_ready;
  logic [OPW-1:0] req0_op = '0, req1_op = '0;
  logic [W-1:0]   req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic           rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [W-1:0]   rsp0_data, rsp1_data;
  logic           fu_start, fu_abort, busy, timeout_err;
  logic [OPW-1:0] fu_op;
  logic [W-1:0]   fu_a, fu_b;
  logic           fu_done = 1'b0;
  logic [W-1:0]   fu_result = '0;

  fpu_share_arbiter #(.W(W), .OPW(OPW), .TO_CYCLES(TO)) dut (
    .CLK(CLK), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
    .fu_start(fu_start), .fu_op(fu_op), .fu_a(fu_a), .fu_b(fu_b),
    .fu_done(fu_done), .fu_result(fu_result), .fu_abort(fu_abort),
    .busy(busy), .timeout_err(timeout_err)
  );

  initial forever #5 CLK = ~CLK;

  typedef struct {
    logic           v0, v1;
    logic [OPW-1:0] op0, op1;
    logic [W-1:0]   a0, b0, a1, b1;
    int             lat;     // unit answers lat cycles after fu_start; 0 = never
    logic [W-1:0]   res;
    int             owner;
    bit             err;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  logic [67:0] sb_q[$];
  bit   sticky = 1'b0;

  int         fu_lat = 0;
  logic [W-1:0] fu_res = '0;
  int         stray_req = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic v0, input logic v1, input int lat, input logic [W-1:0] res,
                              input int owner, input bit err, input int seed);
    vec_t v;
    v.v0 = v0; v.v1 = v1; v.lat = lat; v.res = res; v.owner = owner; v.err = err;
    v.op0 = 4'(seed);       v.a0 = 32'h1000_0000 + 32'(seed); v.b0 = 32'h2000_0000 + 32'(seed);
    v.op1 = 4'(seed + 8);   v.a1 = 32'h5000_0000 + 32'(seed); v.b1 = 32'h6000_0000 + 32'(seed);
    return v;
  endfunction

  // FP-unit model: pulses fu_done lat cycles after fu_start, or a stray pulse on request.
  initial begin
    int lat;
    int stray_seen;
    logic [W-1:0] res;
    stray_seen = 0;
    forever begin
      @(negedge CLK);
      if (stray_req != stray_seen) begin
        stray_seen = stray_req;
        fu_done = 1'b1; fu_result = 32'hDEAD_BEEF;
        @(negedge CLK);
        fu_done = 1'b0; fu_result = '0;
      end else if (fu_start && !reset && fu_lat != 0) begin
        lat = fu_lat; res = fu_res;
        repeat (lat) @(negedge CLK);
        fu_done = 1'b1; fu_result = res;
        @(negedge CLK);
        fu_done = 1'b0; fu_result = '0;
      end
    end
  end

  // Response monitor: every rsp pulse must match the oldest outstanding expectation.
  initial forever begin
    @(negedge CLK); #1;
    if (rsp0_valid || rsp1_valid) begin
      if (sb_q.size() == 0) check("rsp_unexpected", {rsp0_valid, rsp1_valid}, 2'b00);
      else check("rsp_payload", {rsp0_valid, rsp1_valid, rsp0_data, rsp1_data, rsp0_err, rsp1_err},
                 sb_q.pop_front());
    end
  end

  task automatic run_vec(input vec_t v, input string tag);
    logic [OPW-1:0] eop;
    logic [W-1:0]   ea, eb, edata;
    int rsp_k, abort_k;
    bit done;
    eop = (v.owner == 1) ? v.op1 : v.op0;
    ea  = (v.owner == 1) ? v.a1  : v.a0;
    eb  = (v.owner == 1) ? v.b1  : v.b0;
    edata = v.err ? '0 : v.res;
    sticky = sticky | v.err;
    @(negedge CLK);
    fu_lat = v.lat; fu_res = v.res;
    req0_valid = v.v0; req0_op = v.op0; req0_a = v.a0; req0_b = v.b0;
    req1_valid = v.v1; req1_op = v.op1; req1_a = v.a1; req1_b = v.b1;
    #1;
    check({tag, "_grant"}, {req0_ready, req1_ready}, (v.owner == 1) ? 2'b01 : 2'b10);
    if (req0_ready || req1_ready) begin
      if (v.owner == 1) sb_q.push_back({1'b0, 1'b1, 32'h0, edata, 1'b0, v.err});
      else              sb_q.push_back({1'b1, 1'b0, edata, 32'h0, v.err, 1'b0});
    end
    @(negedge CLK);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    check({tag, "_issue"}, {fu_start, busy, req0_ready, req1_ready, fu_op, fu_a, fu_b},
          {1'b1, 1'b1, 1'b0, 1'b0, eop, ea, eb});
    rsp_k = 0; abort_k = 0; done = 1'b0;
    for (int k = 1; k <= TO + 8; k++) begin
      @(negedge CLK); #1;
      if (fu_abort) abort_k = k;
      if (rsp0_valid || rsp1_valid) rsp_k = k;
      if (!busy) begin done = 1'b1; break; end
    end
    check({tag, "_back_idle"}, done, 1'b1);
    check({tag, "_abort_cycle"}, abort_k, v.err ? TO : 0);
    check({tag, "_rsp_cycle"}, rsp_k, v.err ? TO + 1 : v.lat + 1);
    check({tag, "_sticky_hold"}, {timeout_err, fu_op, fu_a, fu_b}, {sticky, eop, ea, eb});
  endtask

  vec_t vecs[8];

  initial begin
    bit aborted;
    bit tie0;
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    bit saw_abort;
    // Round-robin from reset, then single op, timeout, collision, post-timeout tie.
    vecs[0] = mk(1, 1, 2, 32'hA000_0001, 0, 0, 1);
    vecs[1] = mk(1, 1, 2, 32'hA000_0002, 1, 0, 2);
    vecs[2] = mk(1, 1, 2, 32'hA000_0003, 0, 0, 3);
    vecs[3] = mk(1, 1, 2, 32'hA000_0004, 1, 0, 4);
    vecs[4] = mk(1, 0, 3, 32'h4040_0000, 0, 0, 5);
    vecs[4].op0 = 4'b0011; vecs[4].a0 = 32'h3F80_0000; vecs[4].b0 = 32'h4000_0000;
    vecs[5] = mk(0, 1, 0, 32'h0,         1, 1, 6);
    vecs[6] = mk(1, 0, TO, 32'hC0FF_EE00, 0, 0, 7);
    vecs[7] = mk(1, 1, 1, 32'hB000_0008, 1, 0, 9);

    repeat (2) @(negedge CLK);
    #1;
    check("rst_ctrl", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err,
                       fu_start, fu_abort, busy, timeout_err, fu_op}, '0);
    check("rst_rsp_data", {rsp0_data, rsp1_data}, '0);
    check("rst_fu_data", {fu_a, fu_b}, '0);
    @(negedge CLK);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Stray done while idle must be dropped.
    @(negedge CLK);
    stray_req++;
    repeat (3) @(negedge CLK);
    #1;
    check("stray_idle", {busy, rsp0_valid, rsp1_valid}, 3'b000);
    run_vec(mk(0, 1, 2, 32'h1234_5678, 1, 0, 10), "after_stray");

    // Reset two cycles after fu_start while waiting on a unit that never answers.
    @(negedge CLK);
    fu_lat = 0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge CLK);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    check("rstwait_issue", fu_start, 1'b1);
    saw_abort = 1'b0;
    @(negedge CLK); #1; saw_abort |= fu_abort;
    @(negedge CLK); reset = 1'b1; #1; saw_abort |= fu_abort;
    @(negedge CLK); reset = 1'b0; #1;
    check("rstwait_no_abort", saw_abort, 1'b0);
    check("rstwait_ctrl", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err,
                           fu_start, fu_abort, busy, timeout_err, fu_op}, '0);
    check("rstwait_data", {rsp0_data, rsp1_data, fu_a, fu_b}, '0);
    sticky = 1'b0;
    run_vec(mk(1, 1, 1, 32'h0BAD_F00D, 0, 0, 11), "after_reset");

    repeat (3) @(negedge CLK);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
